// File: rtl/mem_port_arb_pkg.sv
// Shared encodings for the memory-port arbiter and the core-side glue that drives it.
package mem_port_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    // Opcodes the core uses to decide which MEM-stage ops raise i_dm_req as loads.
    localparam logic [6:0] LOAD    = 7'b0000011;
    localparam logic [6:0] LOAD_FP = 7'b0000111;

endpackage

// File: rtl/mem_port_arb.sv
// Shares one memory bus port between instruction fetch and data memory,
// one transaction at a time, data first with a bounded streak, plus a response watchdog.
//
// state | meaning
// IDLE  | sample requests, pick owner, latch its command
// CMD   | bus command valid, waiting for i_bus_ack
// WAIT  | command accepted, waiting for i_bus_rvd or timeout
// RESP  | owner's vd pulse, back to IDLE next cycle
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int STREAK_MAX = 4,
    parameter int TIMEOUT    = 255,
    parameter int TW         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic [31:0] o_if_rdata,
    output logic        o_if_vd,
    input  logic        i_dm_req,
    input  logic        i_dm_we,
    input  logic [31:0] i_dm_addr,
    input  logic [31:0] i_dm_wdata,
    input  logic [3:0]  i_dm_wstrb,
    output logic [31:0] o_dm_rdata,
    output logic        o_dm_vd,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wstrb,
    input  logic        i_bus_ack,
    input  logic        i_bus_rvd,
    input  logic [31:0] i_bus_rdata,
    output logic        o_err,
    output logic        o_busy
);

    localparam int            SW         = $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_TOP = SW'(STREAK_MAX);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    arb_state_e    state_q, state_d;
    logic          owner_q, owner_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic [3:0]    bus_wstrb_q, bus_wstrb_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;
    logic          err_q, err_d;
    logic          grant_dm;

    // Data wins unless fetch has already waited through STREAK_MAX data grants.
    assign grant_dm = i_dm_req && (!i_if_req || (streak_q < STREAK_TOP));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        tmo_d       = tmo_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_dm_req || i_if_req) begin
                    state_d   = ST_CMD;
                    bus_req_d = 1'b1;
                    if (grant_dm) begin
                        owner_d     = OWN_DM;
                        bus_we_d    = i_dm_we;
                        bus_addr_d  = i_dm_addr;
                        bus_wdata_d = i_dm_we ? i_dm_wdata : 32'h0;
                        bus_wstrb_d = i_dm_we ? i_dm_wstrb : 4'h0;
                        // grant_dm with if_req high implies streak_q < STREAK_TOP
                        streak_d    = i_if_req ? streak_q + SW'(1) : '0;
                    end else begin
                        owner_d     = OWN_IF;
                        bus_we_d    = 1'b0;
                        bus_addr_d  = i_if_addr;
                        bus_wdata_d = 32'h0;
                        bus_wstrb_d = 4'h0;
                        streak_d    = '0;
                    end
                end
            end
            ST_CMD: begin
                if (i_bus_ack) begin
                    bus_req_d = 1'b0;
                    tmo_d     = '0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                tmo_d = tmo_q + TW'(1);
                if (i_bus_rvd) begin
                    if (owner_q == OWN_DM) dm_rdata_d = i_bus_rdata;
                    else                   if_rdata_d = i_bus_rdata;
                    state_d = ST_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    if (owner_q == OWN_DM) dm_rdata_d = 32'h0;
                    else                   if_rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            streak_q    <= '0;
            tmo_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_wstrb_q <= 4'h0;
            if_rdata_q  <= 32'h0;
            dm_rdata_q  <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            err_q       <= err_d;
        end
    end

    assign o_bus_req   = bus_req_q;
    assign o_bus_we    = bus_we_q;
    assign o_bus_addr  = bus_addr_q;
    assign o_bus_wdata = bus_wdata_q;
    assign o_bus_wstrb = bus_wstrb_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_dm_rdata  = dm_rdata_q;
    assign o_if_vd     = (state_q == ST_RESP) && (owner_q == OWN_IF);
    assign o_dm_vd     = (state_q == ST_RESP) && (owner_q == OWN_DM);
    assign o_err       = err_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: inputs change and outputs are checked on the falling edge.
module tb_mem_port_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_if_req = 1'b0;
    logic [31:0] i_if_addr = 32'h0;
    logic [31:0] o_if_rdata;
    logic        o_if_vd;
    logic        i_dm_req = 1'b0;
    logic        i_dm_we = 1'b0;
    logic [31:0] i_dm_addr = 32'h0;
    logic [31:0] i_dm_wdata = 32'h0;
    logic [3:0]  i_dm_wstrb = 4'h0;
    logic [31:0] o_dm_rdata;
    logic        o_dm_vd;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_wstrb;
    logic        i_bus_ack = 1'b0;
    logic        i_bus_rvd = 1'b0;
    logic [31:0] i_bus_rdata = 32'h0;
    logic        o_err;
    logic        o_busy;

    int checks = 0;
    int failures = 0;

    bit exp_dm [0:9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    mem_port_arb #(.STREAK_MAX(4), .TIMEOUT(255), .TW(8)) dut (
        .clk(clk), .rst(rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_rdata(o_if_rdata), .o_if_vd(o_if_vd),
        .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr),
        .i_dm_wdata(i_dm_wdata), .i_dm_wstrb(i_dm_wstrb),
        .o_dm_rdata(o_dm_rdata), .o_dm_vd(o_dm_vd),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_wdata(o_bus_wdata), .o_bus_wstrb(o_bus_wstrb),
        .i_bus_ack(i_bus_ack), .i_bus_rvd(i_bus_rvd), .i_bus_rdata(i_bus_rdata),
        .o_err(o_err), .o_busy(o_busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset
        tick(); tick();
        chk("rst_bus", {o_bus_req, o_bus_we, o_bus_wstrb, o_bus_addr, 26'h0}, 64'h0);
        chk("rst_wdata", o_bus_wdata, 32'h0);
        chk("rst_rdata", {o_if_rdata, o_dm_rdata}, 64'h0);
        chk("rst_flags", {o_if_vd, o_dm_vd, o_err, o_busy}, 4'h0);

        // 1: single fetch, ack in first CMD cycle, rvd in second WAIT cycle
        rst = 1'b1; i_if_req = 1'b1; i_if_addr = 32'h100;
        tick();
        chk("t1_cmd", {o_bus_req, o_bus_we, o_bus_wstrb, o_bus_addr}, {1'b1, 1'b0, 4'h0, 32'h100});
        chk("t1_busy", o_busy, 1'b1);
        i_bus_ack = 1'b1;
        tick();
        i_bus_ack = 1'b0;
        chk("t1_req_drop", o_bus_req, 1'b0);
        tick();
        i_bus_rvd = 1'b1; i_bus_rdata = 32'hDEADBEEF;
        tick();
        i_bus_rvd = 1'b0; i_if_req = 1'b0;
        chk("t1_vd", {o_if_vd, o_dm_vd, o_err}, 3'b100);
        chk("t1_rdata", o_if_rdata, 32'hDEADBEEF);
        tick();
        chk("t1_idle", {o_if_vd, o_busy, o_err}, 3'b000);
        chk("t1_hold", o_if_rdata, 32'hDEADBEEF);

        // 2: both requesters held, streak limit 4
        i_if_req = 1'b1; i_if_addr = 32'h300;
        i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h400;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_grant_addr", o_bus_addr, exp_dm[i] ? 32'h400 : 32'h300);
            i_bus_ack = 1'b1;
            tick();
            i_bus_ack = 1'b0;
            i_bus_rvd = 1'b1; i_bus_rdata = 32'h1000 + i;
            tick();
            i_bus_rvd = 1'b0;
            chk("t2_vd", {o_if_vd, o_dm_vd}, exp_dm[i] ? 2'b01 : 2'b10);
            chk("t2_rdata", exp_dm[i] ? o_dm_rdata : o_if_rdata, 32'h1000 + i);
            tick();
        end
        i_if_req = 1'b0; i_dm_req = 1'b0;

        // 3: store, ack after two CMD cycles
        i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_addr = 32'h2000;
        i_dm_wdata = 32'h12345678; i_dm_wstrb = 4'b0011;
        tick();
        chk("t3_cmd0", {o_bus_req, o_bus_we, o_bus_wstrb, o_bus_addr}, {1'b1, 1'b1, 4'b0011, 32'h2000});
        chk("t3_wdata0", o_bus_wdata, 32'h12345678);
        tick();
        chk("t3_cmd1", {o_bus_req, o_bus_we, o_bus_wstrb, o_bus_addr}, {1'b1, 1'b1, 4'b0011, 32'h2000});
        chk("t3_wdata1", o_bus_wdata, 32'h12345678);
        i_bus_ack = 1'b1;
        tick();
        i_bus_ack = 1'b0;
        chk("t3_req_drop", o_bus_req, 1'b0);
        i_bus_rvd = 1'b1; i_bus_rdata = 32'h0000A5A5;
        tick();
        i_bus_rvd = 1'b0; i_dm_req = 1'b0; i_dm_we = 1'b0;
        chk("t3_vd", {o_if_vd, o_dm_vd, o_err}, 3'b010);
        chk("t3_rdata", o_dm_rdata, 32'h0000A5A5);
        tick();

        // 4: read with ack withheld 10 cycles; a stray rvd during CMD is ignored
        i_dm_req = 1'b1; i_dm_addr = 32'h3000; i_dm_wdata = 32'hFFFFFFFF; i_dm_wstrb = 4'hF;
        tick();
        i_bus_rvd = 1'b1; i_bus_rdata = 32'h11111111;
        for (int i = 0; i < 10; i++) begin
            chk("t4_cmd_stable", {o_bus_req, o_bus_we, o_bus_wstrb, o_bus_addr, o_busy, o_err, o_dm_vd},
                {1'b1, 1'b0, 4'h0, 32'h3000, 1'b1, 1'b0, 1'b0});
            tick();
        end
        i_bus_rvd = 1'b0;
        chk("t4_cmd_last", {o_bus_req, o_bus_addr}, {1'b1, 32'h3000});
        i_bus_ack = 1'b1;
        tick();
        i_bus_ack = 1'b0;
        chk("t4_wait", {o_bus_req, o_busy}, 2'b01);

        // 5a: no rvd -> abort after 255 WAIT cycles
        for (int i = 0; i < 254; i++) tick();
        chk("t5a_w255", {o_busy, o_err, o_dm_vd}, 3'b100);
        chk("t5a_rdata_pre", o_dm_rdata, 32'h0000A5A5);
        tick();
        i_dm_req = 1'b0;
        chk("t5a_abort", {o_err, o_dm_vd, o_if_vd}, 3'b110);
        chk("t5a_rdata", o_dm_rdata, 32'h0);
        tick();
        chk("t5a_idle", {o_err, o_dm_vd, o_busy}, 3'b000);

        // 5b: rvd on the 255th WAIT cycle beats the timeout
        i_dm_req = 1'b1; i_dm_addr = 32'h3004;
        tick();
        i_bus_ack = 1'b1;
        tick();
        i_bus_ack = 1'b0;
        for (int i = 0; i < 254; i++) tick();
        chk("t5b_w255", {o_busy, o_err, o_dm_vd}, 3'b100);
        i_bus_rvd = 1'b1; i_bus_rdata = 32'hCAFEF00D;
        tick();
        i_bus_rvd = 1'b0; i_dm_req = 1'b0;
        chk("t5b_resp", {o_err, o_dm_vd}, 2'b01);
        chk("t5b_rdata", o_dm_rdata, 32'hCAFEF00D);
        tick();

        // 6: reset in WAIT; late rvd afterwards is ignored
        i_dm_req = 1'b1; i_dm_addr = 32'h5000;
        tick();
        i_bus_ack = 1'b1;
        tick();
        i_bus_ack = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1; i_dm_req = 1'b0;
        chk("t6_bus", {o_bus_req, o_bus_we, o_bus_wstrb, o_bus_addr}, 38'h0);
        chk("t6_rdata", {o_if_rdata, o_dm_rdata}, 64'h0);
        chk("t6_flags", {o_if_vd, o_dm_vd, o_err, o_busy}, 4'h0);
        i_bus_rvd = 1'b1; i_bus_rdata = 32'h77777777;
        tick();
        chk("t6_late_rvd", {o_dm_vd, o_if_vd, o_busy, o_err}, 4'h0);
        chk("t6_late_rdata", o_dm_rdata, 32'h0);
        i_bus_rvd = 1'b0;
        tick();
        chk("t6_quiet", {o_dm_vd, o_if_vd, o_busy, o_bus_req}, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
